// File: rtl/option_pkg.sv
// rtl/option_pkg.sv - shared widths, state encoding and option-type constants
package option_pkg;

    localparam int PRICE_W        = 12;
    localparam int PATH_LEN       = 8;
    localparam int LOG2_PATH_LEN  = 3;
    localparam int LOG2_MAX_PATHS = 10;
    localparam int CFG_N_W        = 4;

    localparam int SUM_W = PRICE_W + LOG2_PATH_LEN;
    localparam int ACC_W = PRICE_W + LOG2_MAX_PATHS;
    localparam int CNT_W = LOG2_MAX_PATHS + 1;

    localparam logic CALL = 1'b0;
    localparam logic PUT  = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/asian_payoff.sv
// rtl/asian_payoff.sv - combinational arithmetic-average payoff of one 8-sample path
module asian_payoff
    import option_pkg::*;
(
    input  logic [SUM_W-1:0]   sum,
    input  logic [PRICE_W-1:0] strike,
    input  logic               put,
    output logic [PRICE_W-1:0] payoff
);

    logic [PRICE_W-1:0] avg;

    // Dropping the low bits divides by PATH_LEN with truncation.
    assign avg = sum[SUM_W-1:LOG2_PATH_LEN];

    always_comb begin
        payoff = '0;
        if (put == CALL) begin
            if (avg > strike) begin
                payoff = avg - strike;
            end
        end else begin
            if (strike > avg) begin
                payoff = strike - avg;
            end
        end
    end

endmodule

// File: rtl/asian_payoff_accum.sv
// rtl/asian_payoff_accum.sv - per-path Asian payoff accumulation and mean-price reporting
module asian_payoff_accum
    import option_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cfg_load,
    input  logic [PRICE_W-1:0]       cfg_strike,
    input  logic                     cfg_put,
    input  logic [CFG_N_W-1:0]       cfg_log2_n,
    input  logic                     valid,
    input  logic [PRICE_W-1:0]       path,
    output logic                     busy,
    output logic                     done,
    output logic [PRICE_W-1:0]       price,
    output logic [ACC_W-1:0]         payoff_sum,
    output logic [CNT_W-1:0]         path_cnt,
    output logic                     err
);

    state_e                   state_q, state_d;
    logic [LOG2_PATH_LEN-1:0] idx_q, idx_d;
    logic [SUM_W-1:0]         sum_q, sum_d;
    logic [SUM_W-1:0]         fin_q, fin_d;
    logic                     fin_vld_q, fin_vld_d;
    logic [PRICE_W-1:0]       pay_q, pay_d;
    logic                     pay_vld_q, pay_vld_d;
    logic [ACC_W-1:0]         acc_q, acc_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [CNT_W-1:0]         taken_q, taken_d;
    logic [PRICE_W-1:0]       price_q, price_d;
    logic                     done_q, done_d;
    logic                     err_q, err_d;
    logic [PRICE_W-1:0]       strike_q, strike_d;
    logic                     put_q, put_d;
    logic [CFG_N_W-1:0]       log2n_q, log2n_d;

    logic [SUM_W-1:0]         sum_next;
    logic [PRICE_W-1:0]       payoff_w;
    logic [ACC_W-1:0]         acc_new;
    logic [CNT_W-1:0]         cnt_new;
    logic [CNT_W-1:0]         target;

    assign sum_next = sum_q + SUM_W'(path);
    assign acc_new  = acc_q + ACC_W'(pay_q);
    assign cnt_new  = cnt_q + CNT_W'(1);
    assign target   = CNT_W'(1) << log2n_q;

    asian_payoff u_payoff (
        .sum    (fin_q),
        .strike (strike_q),
        .put    (put_q),
        .payoff (payoff_w)
    );

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        sum_d     = sum_q;
        fin_d     = fin_q;
        fin_vld_d = 1'b0;
        pay_d     = pay_q;
        pay_vld_d = 1'b0;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        taken_d   = taken_q;
        price_d   = price_q;
        done_d    = 1'b0;
        err_d     = err_q;
        strike_d  = strike_q;
        put_d     = put_q;
        log2n_d   = log2n_q;

        if (cfg_load) begin
            strike_d = cfg_strike;
            put_d    = cfg_put;
            log2n_d  = (cfg_log2_n > CFG_N_W'(LOG2_MAX_PATHS)) ? CFG_N_W'(LOG2_MAX_PATHS) : cfg_log2_n;
            idx_d    = '0;
            sum_d    = '0;
            acc_d    = '0;
            cnt_d    = '0;
            taken_d  = '0;
            err_d    = 1'b0;
            state_d  = RUN;
        end else if (state_q == RUN) begin
            pay_d     = payoff_w;
            pay_vld_d = fin_vld_q;

            if (pay_vld_q) begin
                acc_d = acc_new;
                cnt_d = cnt_new;
                if (cnt_new == target) begin
                    price_d = PRICE_W'(acc_new >> log2n_q);
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end

            // Once every path of the run has been captured, further samples are dropped.
            if (taken_q != target) begin
                if (valid) begin
                    sum_d = sum_next;
                    idx_d = idx_q + LOG2_PATH_LEN'(1);
                    if (idx_q == LOG2_PATH_LEN'(PATH_LEN - 1)) begin
                        fin_d     = sum_next;
                        fin_vld_d = 1'b1;
                        sum_d     = '0;
                        taken_d   = taken_q + CNT_W'(1);
                    end
                end else if (idx_q != '0) begin
                    idx_d = '0;
                    sum_d = '0;
                    err_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            sum_q     <= '0;
            fin_q     <= '0;
            fin_vld_q <= 1'b0;
            pay_q     <= '0;
            pay_vld_q <= 1'b0;
            acc_q     <= '0;
            cnt_q     <= '0;
            taken_q   <= '0;
            price_q   <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            strike_q  <= '0;
            put_q     <= 1'b0;
            log2n_q   <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            sum_q     <= sum_d;
            fin_q     <= fin_d;
            fin_vld_q <= fin_vld_d;
            pay_q     <= pay_d;
            pay_vld_q <= pay_vld_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            taken_q   <= taken_d;
            price_q   <= price_d;
            done_q    <= done_d;
            err_q     <= err_d;
            strike_q  <= strike_d;
            put_q     <= put_d;
            log2n_q   <= log2n_d;
        end
    end

    assign busy       = (state_q == RUN);
    assign done       = done_q;
    assign price      = price_q;
    assign payoff_sum = acc_q;
    assign path_cnt   = cnt_q;
    assign err        = err_q;

endmodule

// File: tb/tb_asian_payoff_accum.sv
// tb/tb_asian_payoff_accum.sv - self-checking bench for asian_payoff_accum
module tb_asian_payoff_accum;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_load = 1'b0;
    logic [11:0] cfg_strike = '0;
    logic        cfg_put = 1'b0;
    logic [3:0]  cfg_log2_n = '0;
    logic        valid = 1'b0;
    logic [11:0] path = '0;
    logic        busy, done, err;
    logic [11:0] price;
    logic [21:0] payoff_sum;
    logic [10:0] path_cnt;

    asian_payoff_accum dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_load   (cfg_load),
        .cfg_strike (cfg_strike),
        .cfg_put    (cfg_put),
        .cfg_log2_n (cfg_log2_n),
        .valid      (valid),
        .path       (path),
        .busy       (busy),
        .done       (done),
        .price      (price),
        .payoff_sum (payoff_sum),
        .path_cnt   (path_cnt),
        .err        (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int done_seen = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: transaction-level view of runs, paths and payoffs.
    int     cyc = 0;
    bit     m_run = 0, m_done = 0, m_err = 0, m_put = 0;
    int     m_price = 0, m_cnt = 0, m_n = 0, m_k = 0, captured = 0;
    longint m_sum = 0;
    int     cur[$];
    int     pend_pay[$];
    int     pend_due[$];
    int     p_tmp;

    function automatic int payoff_of(input int tot, input int k, input bit put);
        int avg;
        avg = tot / 8;
        if (put) return (k > avg) ? k - avg : 0;
        return (avg > k) ? avg - k : 0;
    endfunction

    always @(posedge clk) begin
        cyc++;
        m_done = 0;
        if (rst) begin
            m_run = 0; m_price = 0; m_sum = 0; m_cnt = 0; m_err = 0; captured = 0;
            cur.delete(); pend_pay.delete(); pend_due.delete();
        end else if (cfg_load) begin
            m_k = int'(cfg_strike);
            m_put = cfg_put;
            m_n = (int'(cfg_log2_n) > 10) ? 10 : int'(cfg_log2_n);
            m_sum = 0; m_cnt = 0; m_err = 0; captured = 0;
            cur.delete(); pend_pay.delete(); pend_due.delete();
            m_run = 1;
        end else if (m_run) begin
            if (pend_due.size() > 0 && pend_due[0] == cyc) begin
                p_tmp = pend_pay.pop_front();
                void'(pend_due.pop_front());
                m_sum += p_tmp;
                m_cnt++;
                if (m_cnt == (1 << m_n)) begin
                    m_price = int'(m_sum >> m_n);
                    m_done = 1;
                    m_run = 0;
                end
            end
            if (captured < (1 << m_n)) begin
                if (valid) begin
                    cur.push_back(int'(path));
                    if (cur.size() == 8) begin
                        p_tmp = 0;
                        foreach (cur[i]) p_tmp += cur[i];
                        pend_pay.push_back(payoff_of(p_tmp, m_k, m_put));
                        pend_due.push_back(cyc + 2);
                        captured++;
                        cur.delete();
                    end
                end else if (cur.size() > 0) begin
                    cur.delete();
                    m_err = 1;
                end
            end
        end
        #1;
        chk("busy", 32'(busy), 32'(m_run));
        chk("done", 32'(done), 32'(m_done));
        chk("price", 32'(price), 32'(m_price));
        chk("payoff_sum", 32'(payoff_sum), 32'(m_sum));
        chk("path_cnt", 32'(path_cnt), 32'(m_cnt));
        chk("err", 32'(err), 32'(m_err));
        if (done === 1'b1) done_seen++;
    end

    task automatic load(input int k, input bit p, input int n);
        cfg_strike = k[11:0];
        cfg_put = p;
        cfg_log2_n = n[3:0];
        cfg_load = 1'b1;
        valid = 1'b0;
        @(negedge clk);
        cfg_load = 1'b0;
    endtask

    task automatic send(input int v);
        valid = 1'b1;
        path = v[11:0];
        @(negedge clk);
    endtask

    task automatic gap(input int c);
        valid = 1'b0;
        repeat (c) @(negedge clk);
    endtask

    task automatic wait_done(input int d0, input int budget);
        for (int i = 0; i < budget && done_seen == d0; i++) @(negedge clk);
        chk("done_timeout", 32'(done_seen > d0), 32'd1);
    endtask

    task automatic send_path(input int v);
        for (int i = 0; i < 8; i++) send(v);
    endtask

    int d0;
    int x;

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_price", 32'(price), 32'd0);
        chk("rst_sum", 32'(payoff_sum), 32'd0);
        chk("rst_cnt", 32'(path_cnt), 32'd0);
        chk("rst_err", 32'(err), 32'd0);

        send_path(1200);
        gap(2);
        chk("idle_ignores", 32'(path_cnt), 32'd0);

        load(1000, 1'b0, 0);
        send_path(1200);
        gap(2);
        chk("s1_done_latency", 32'(done), 32'd1);
        chk("s1_price", 32'(price), 32'd200);
        chk("s1_cnt", 32'(path_cnt), 32'd1);
        chk("s1_busy", 32'(busy), 32'd0);

        for (int p = 0; p < 2; p++) begin
            d0 = done_seen;
            load(1000, p[0], 0);
            for (int i = 0; i < 8; i++) send(800 + 100 * i);
            gap(1);
            wait_done(d0, 10);
            chk("s2_price", 32'(price), (p == 0) ? 32'd150 : 32'd0);
        end

        d0 = done_seen;
        load(1000, 1'b0, 2);
        send_path(1100); send_path(1200); send_path(900); send_path(1300);
        send(4000); send(4000);
        wait_done(d0, 10);
        gap(4);
        chk("s3_sum", 32'(payoff_sum), 32'd600);
        chk("s3_price", 32'(price), 32'd150);
        chk("s3_one_done", 32'(done_seen - d0), 32'd1);

        for (int p = 0; p < 2; p++) begin
            d0 = done_seen;
            load(1000 + p, p[0], 0);
            for (int i = 0; i < 7; i++) send(1000);
            send(1007);
            gap(1);
            wait_done(d0, 10);
            chk("trunc_price", 32'(price), (p == 0) ? 32'd0 : 32'd1);
        end

        d0 = done_seen;
        load(1000, 1'b0, 0);
        for (int i = 0; i < 5; i++) send(1100);
        gap(2);
        chk("short_err", 32'(err), 32'd1);
        chk("short_cnt", 32'(path_cnt), 32'd0);
        send_path(1100);
        gap(1);
        wait_done(d0, 10);
        chk("short_price", 32'(price), 32'd100);
        chk("short_err_sticky", 32'(err), 32'd1);

        load(1000, 1'b0, 2);
        send_path(1200); send_path(1200);
        gap(3);
        chk("abort_cnt_before", 32'(path_cnt), 32'd2);
        chk("abort_sum_before", 32'(payoff_sum), 32'd400);
        load(1000, 1'b0, 2);
        chk("abort_cnt", 32'(path_cnt), 32'd0);
        chk("abort_sum", 32'(payoff_sum), 32'd0);
        chk("abort_price_held", 32'(price), 32'd100);
        send(1200); send(1200); send(1200);
        rst = 1'b1; valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_price", 32'(price), 32'd0);
        chk("midrst_cnt", 32'(path_cnt), 32'd0);
        chk("midrst_sum", 32'(payoff_sum), 32'd0);

        d0 = done_seen;
        load(0, 1'b0, 10);
        for (int i = 0; i < 1024; i++) send_path(4095);
        gap(1);
        wait_done(d0, 10);
        chk("max_sum", 32'(payoff_sum), 32'd4193280);
        chk("max_price", 32'(price), 32'd4095);

        d0 = done_seen;
        load(95, 1'b0, 15);
        for (int i = 0; i < 1024; i++) send_path(4095);
        gap(1);
        wait_done(d0, 10);
        chk("sat_sum", 32'(payoff_sum), 32'd4096000);
        chk("sat_price", 32'(price), 32'd4000);

        for (int r = 0; r < 25; r++) begin
            d0 = done_seen;
            load(int'($urandom_range(0, 4095)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
            for (int c = 0; c < 600 && done_seen == d0; c++) begin
                x = int'($urandom_range(0, 199));
                path = 12'($urandom_range(0, 4095));
                if (x == 0) begin
                    cfg_strike = 12'($urandom_range(0, 4095));
                    cfg_put = 1'($urandom_range(0, 1));
                    cfg_log2_n = 4'($urandom_range(0, 3));
                    cfg_load = 1'b1;
                    valid = 1'($urandom_range(0, 1));
                    @(negedge clk);
                    cfg_load = 1'b0;
                end else if (x == 1) begin
                    rst = 1'b1;
                    valid = 1'b1;
                    @(negedge clk);
                    rst = 1'b0;
                end else begin
                    valid = (x < 180);
                    @(negedge clk);
                end
            end
            gap(3);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/asian_payoff_accum.md
Name: asian_payoff_accum

Overview:
- Downstream consumer of Path_Gen in the option-pricing Monte Carlo datapath.
- Each path arrives as 8 consecutive valid samples of 12-bit unsigned price.
- Per path: computes the arithmetic-average (Asian) payoff against strike K, as call or put.
- Accumulates payoffs over 2^cfg_log2_n paths, then reports the mean payoff (undiscounted option price) with a done pulse.

Parameters:
- PRICE_W, 12: width of path samples, strike and price output.
- PATH_LEN, 8: samples per path; fixed power of two, average is sum >> 3.
- LOG2_MAX_PATHS, 10: max log2 of paths per run; sizes accumulator and counter.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- cfg_load  in  1  one-cycle pulse; latches cfg_*, clears state, starts a run.
- cfg_strike  in  PRICE_W  strike K, unsigned, same fixed-point format as path.
- cfg_put  in  1  0 = call max(avg-K,0); 1 = put max(K-avg,0).
- cfg_log2_n  in  4  log2 of path count; values above LOG2_MAX_PATHS saturate to LOG2_MAX_PATHS.
- valid  in  1  path sample valid (Path_Gen valid).
- path  in  PRICE_W  path sample (Path_Gen path).
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse when price is updated.
- price  out  PRICE_W  mean payoff, held until next cfg_load or rst.
- payoff_sum  out  PRICE_W+LOG2_MAX_PATHS  raw accumulated payoff sum.
- path_cnt  out  LOG2_MAX_PATHS+1  completed paths in current run.
- err  out  1  sticky; a path ended with fewer than PATH_LEN samples.

Behaviour:
- Reset: all outputs 0, state IDLE, sample index 0, internal sum 0.
- States and transitions:
  - IDLE: valid ignored; cfg_load -> RUN.
  - RUN: accepts samples.
  - DONE: valid ignored; cfg_load -> RUN.
- cfg_load in any state:
  - latches config; clears path_cnt, payoff_sum, sample index, err; price holds old value.
  - Same cycle as valid: cfg_load wins, the sample is dropped.
- Sample collection (RUN):
  - each valid cycle adds path to a 15-bit sample sum; index increments 0..7.
  - On index 7, the final sum (including this sample) goes to payoff; index wraps to 0.
  - Back-to-back paths (16+ consecutive valid cycles) are legal with no gap.
- Short path:
  - valid low while index is non-zero discards the partial path: index -> 0, sum -> 0, err := 1.
  - path_cnt is unchanged.
- Payoff arithmetic:
  - avg = sum[14:3], truncating.
  - call: avg > K ? avg-K : 0. put: K > avg ? K-avg : 0. Result is 12-bit, never wraps.
- Latency and pipeline:
  - edge E0 captures the 8th sample.
  - E0+1 registers the payoff.
  - E0+2 adds it to payoff_sum and increments path_cnt.
- Run completion:
  - if path_cnt reaches 2^n at E0+2, then at that same edge: price := new sum >> n (truncating), done := 1 for one cycle, state -> DONE.
  - Samples arriving in RUN after the last path's 8th sample are ignored.
- Overflow: not possible. Accumulator width covers 4095·2^LOG2_MAX_PATHS.
- rst mid-run: abandons everything, returns to IDLE, price := 0.

Decomposition:
- Package option_pkg: PRICE_W, PATH_LEN, LOG2_PATH_LEN=3, state encoding (IDLE/RUN/DONE), option-type constants CALL=0/PUT=1.
- Sub-module asian_payoff: 15-bit sum + strike + put flag -> 12-bit payoff; combinational.
- asian_payoff_accum holds the FSM, sample counter, pipeline register and accumulator.

Test Plan:
- K=1000, call, n=0; 8 samples of 1200 -> done pulse 2 cycles after 8th sample; price=200, path_cnt=1, busy falls.
- K=1000, n=0; samples 800,900,…,1500 (avg 1150) -> call price 150; rerun with cfg_put=1 -> price 0.
- K=1000, call, n=2; four back-to-back constant paths 1100,1200,900,1300 -> payoff_sum=600, price=150, exactly one done.
- Truncation: seven samples 1000 plus one 1007 (sum 8007, avg 1000), call K=1000 -> price 0; put K=1001 -> price 1.
- Short path: 5 valid samples then gap -> err=1, path_cnt=0; next full path of 1100, K=1000, n=0 -> price 100, err stays 1.
- Abort/extremes:
  - cfg_load after 2 of 4 paths -> path_cnt=0, payoff_sum=0.
  - rst mid-run -> all outputs 0.
  - K=0 call, n=10, all samples 4095 -> payoff_sum=4193280, price=4095.
